// File: rtl/fwd_pkg.sv
// Shared constants and entry layout for the forwarding / hazard unit.
package fwd_pkg;

    localparam int unsigned FWD_SEL_RF = 0;

    localparam int unsigned STG_EX    = 1;
    localparam int unsigned STG_EXMEM = 2;
    localparam int unsigned STG_MEMWB = 3;

    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;

    localparam int unsigned DEF_AW = 5;
    localparam int unsigned DEF_LW = 2;

    // Reference layout at default widths; the top re-declares it at its parameter widths.
    typedef struct packed {
        logic              valid;
        logic              wb;
        logic [DEF_AW-1:0] dst;
        logic [DEF_LW-1:0] rem;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Youngest-match priority encoder for one source operand over the post-advance entries.
module fwd_match #(
    parameter int unsigned N  = 2,
    parameter int unsigned AW = 5,
    parameter int unsigned SW = 2
) (
    input  logic [AW-1:0]   src_i,
    input  logic            used_i,
    input  logic [N-1:0]    ent_valid_i,
    input  logic [N-1:0]    ent_wb_i,
    input  logic [N-1:0]    ent_pend_i,
    input  logic [N*AW-1:0] ent_dst_i,
    output logic            hit_o,
    output logic [SW-1:0]   sel_o,
    output logic            not_ready_o
);

    logic found;

    // Entry i sits in post-advance stage i+2, so its select is i+1.
    always_comb begin
        found       = 1'b0;
        hit_o       = 1'b0;
        sel_o       = '0;
        not_ready_o = 1'b0;
        if (used_i && (src_i != '0)) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && ent_valid_i[i] && ent_wb_i[i] &&
                    (ent_dst_i[i*AW +: AW] == src_i)) begin
                    found       = 1'b1;
                    hit_o       = 1'b1;
                    sel_o       = SW'(i + 1);
                    not_ready_o = ent_pend_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight register writes per stage; drives EX forward selects and the ID load-use stall.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned AW      = 5,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned MAX_LAT = 2,
    parameter int unsigned LW      = $clog2(MAX_LAT + 1),
    parameter int unsigned SW      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [NUM_SRC*AW-1:0] id_src_i,
    input  logic [NUM_SRC-1:0]    id_src_used_i,
    input  logic                  id_wb_i,
    input  logic [AW-1:0]         id_dst_i,
    input  logic [LW-1:0]         id_lat_i,
    output logic                  stall_o,
    output logic [NUM_SRC*SW-1:0] ex_fwd_sel_o
);

    typedef struct packed {
        logic          valid;
        logic          wb;
        logic [AW-1:0] dst;
        logic [LW-1:0] rem;
    } entry_t;

    localparam int unsigned NPA = DEPTH - 1;

    entry_t                ent_q [1:DEPTH];
    entry_t                ent_d [1:DEPTH];
    logic [NUM_SRC*SW-1:0] sel_q, sel_d;

    logic [NPA-1:0]        pa_valid, pa_wb, pa_pend;
    logic [NPA*AW-1:0]     pa_dst;
    logic [NUM_SRC-1:0]    op_hit, op_nrdy;
    logic [NUM_SRC*SW-1:0] op_sel;
    logic [LW-1:0]         rem_in;
    logic                  bubble;

    // Post-advance view: stages 1..DEPTH-1 shift up one, with rem decremented.
    always_comb begin
        pa_valid = '0;
        pa_wb    = '0;
        pa_pend  = '0;
        pa_dst   = '0;
        for (int unsigned i = 0; i < NPA; i++) begin
            pa_valid[i]          = ent_q[STG_EX + i].valid;
            pa_wb[i]             = ent_q[STG_EX + i].wb;
            pa_pend[i]           = ent_q[STG_EX + i].rem > LW'(1);
            pa_dst[i*AW +: AW]   = ent_q[STG_EX + i].dst;
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_op
        fwd_match #(
            .N  (NPA),
            .AW (AW),
            .SW (SW)
        ) u_match (
            .src_i       (id_src_i[s*AW +: AW]),
            .used_i      (id_src_used_i[s]),
            .ent_valid_i (pa_valid),
            .ent_wb_i    (pa_wb),
            .ent_pend_i  (pa_pend),
            .ent_dst_i   (pa_dst),
            .hit_o       (op_hit[s]),
            .sel_o       (op_sel[s*SW +: SW]),
            .not_ready_o (op_nrdy[s])
        );
    end

    assign stall_o = !hold_i && !flush_i && id_valid_i && (|(op_hit & op_nrdy));
    assign bubble  = stall_o || flush_i || !id_valid_i;

    always_comb begin
        if (id_lat_i < LW'(LAT_ALU)) begin
            rem_in = LW'(LAT_ALU);
        end else if (id_lat_i > LW'(MAX_LAT)) begin
            rem_in = LW'(MAX_LAT);
        end else begin
            rem_in = id_lat_i;
        end
    end

    always_comb begin
        ent_d = ent_q;
        sel_d = sel_q;
        if (!hold_i) begin
            for (int unsigned k = STG_EXMEM; k <= DEPTH; k++) begin
                ent_d[k]     = ent_q[k-1];
                ent_d[k].rem = (ent_q[k-1].rem == '0) ? '0 : ent_q[k-1].rem - LW'(1);
            end
            // Flush kills the EX occupant before it reaches EX/MEM.
            if (flush_i) begin
                ent_d[STG_EXMEM].valid = 1'b0;
            end
            ent_d[STG_EX] = '0;
            if (!bubble) begin
                ent_d[STG_EX].valid = 1'b1;
                ent_d[STG_EX].wb    = id_wb_i && (id_dst_i != '0);
                ent_d[STG_EX].dst   = id_dst_i;
                ent_d[STG_EX].rem   = rem_in;
            end
            sel_d = bubble ? {NUM_SRC{SW'(FWD_SEL_RF)}} : op_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            sel_q <= '0;
        end else begin
            ent_q <= ent_d;
            sel_q <= sel_d;
        end
    end

    assign ex_fwd_sel_o = sel_q;

endmodule
